// File: rtl/logic_gates_pkg.sv
// Shared definitions for the LogicGates unit, its sweeper and benches:
// gate-type codes, sweep sizes and the reference gate function.
package logic_gates_pkg;

  localparam int unsigned NUM_GATES   = 7;
  localparam int unsigned NUM_VECTORS = 28;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned SETTLE_W    = 4;

  localparam logic [IDX_W-1:0] NO_FAIL = 5'h1F;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XOR  = 3'd5,
    GATE_XNOR = 3'd6,
    GATE_RSVD = 3'd7
  } gate_type_e;

  // Expected LogicGates.O; NOT ignores b, the unused code reads as 0.
  function automatic logic gate_ref(input logic a, input logic b, input gate_type_e gateType);
    logic o;
    o = 1'b0;
    case (gateType)
      GATE_AND:  o = a & b;
      GATE_OR:   o = a | b;
      GATE_NOT:  o = ~a;
      GATE_NAND: o = ~(a & b);
      GATE_NOR:  o = ~(a | b);
      GATE_XOR:  o = a ^ b;
      GATE_XNOR: o = ~(a ^ b);
      default:   o = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/logic_gates_sweeper.sv
// Exhaustive self-checking sweeper for LogicGates: drives all 28 vectors,
// scores gate_o against the package reference and pulses done with the verdict.
module logic_gates_sweeper
  import logic_gates_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [4:0]  first_fail,
  output logic [27:0] result,
  output logic        gate_a,
  output logic        gate_b,
  output logic [2:0]  gate_type,
  input  logic        gate_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE_CYCLES - 2);

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] settleCnt;
  logic                expected;

  assign expected = gate_ref(gate_a, gate_b, gate_type_e'(gate_type));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settleCnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= NO_FAIL;
      result     <= '0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      gate_type  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            result     <= '0;
            err_count  <= '0;
            first_fail <= NO_FAIL;
            pass       <= 1'b0;
            idx        <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          gate_type <= idx[4:2];
          gate_a    <= idx[1];
          gate_b    <= idx[0];
          busy      <= 1'b1;
          settleCnt <= '0;
          state     <= (SETTLE_CYCLES > 1) ? SETTLE : SAMPLE;
        end
        // Extra hold cycles so gate_o gets SETTLE_CYCLES full cycles.
        SETTLE: begin
          if (settleCnt == SETTLE_END) begin
            state <= SAMPLE;
          end else begin
            settleCnt <= settleCnt + SETTLE_W'(1);
          end
        end
        SAMPLE: begin
          result[idx] <= gate_o;
          if (gate_o != expected) begin
            err_count <= err_count + 5'd1;
            if (first_fail == NO_FAIL) begin
              first_fail <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            state <= FINISH;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= DRIVE;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          pass  <= (err_count == 5'd0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gates_sweeper.sv
// Directed bench for logic_gates_sweeper: table of gate_o behaviours plus
// hand-timed sequences for restart, reset, back-to-back and slow settle.
module tb_logic_gates_sweeper;

  typedef struct {
    int          mode;       // 0 correct gate, 1 tied low, 2 tied high
    logic [27:0] expResult;
    logic [4:0]  expErr;
    logic [4:0]  expFirst;
    logic        expPass;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  int          mode = 0;

  logic        busy, done, pass, gate_a, gate_b, gate_o;
  logic [4:0]  err_count, first_fail;
  logic [27:0] result;
  logic [2:0]  gate_type;

  logic        busy3, done3, pass3, gate_a3, gate_b3, gate_o3;
  logic [4:0]  err_count3, first_fail3;
  logic [27:0] result3;
  logic [2:0]  gate_type3;

  int vectors = 0;
  int miscompares = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  function automatic logic gateModel(input logic a, input logic b, input logic [2:0] t);
    case (t)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  assign gate_o  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : gateModel(gate_a, gate_b, gate_type);
  assign gate_o3 = gateModel(gate_a3, gate_b3, gate_type3);

  logic_gates_sweeper dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .result(result),
    .gate_a(gate_a), .gate_b(gate_b), .gate_type(gate_type), .gate_o(gate_o)
  );

  logic_gates_sweeper #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_fail(first_fail3), .result(result3),
    .gate_a(gate_a3), .gate_b(gate_b3), .gate_type(gate_type3), .gate_o(gate_o3)
  );

  always @(posedge clk) if (done) doneCount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " pass"}, {31'd0, pass}, 32'd0);
    check({tag, " err_count"}, {27'd0, err_count}, 32'd0);
    check({tag, " first_fail"}, {27'd0, first_fail}, 32'h1F);
    check({tag, " result"}, {4'd0, result}, 32'd0);
    check({tag, " gates"}, {27'd0, gate_type, gate_a, gate_b}, 32'd0);
  endtask

  // Pulse start for one edge (edge 0), run to edge 57 checking timing and scores.
  task automatic runSweep(input string tag, input vec_t v);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@0"}, {31'd0, busy}, 32'd0);
    for (int e = 1; e <= 57; e++) begin
      tick();
      if (e == 1)  check({tag, " busy@1"}, {31'd0, busy}, 32'd1);
      if (e == 55) check({tag, " busy@55"}, {31'd0, busy}, 32'd1);
      if (e == 56) check({tag, " done@56"}, {31'd0, done}, 32'd0);
      if (e == 56) check({tag, " busy@56"}, {31'd0, busy}, 32'd0);
    end
    check({tag, " done@57"}, {31'd0, done}, 32'd1);
    check({tag, " result"}, {4'd0, result}, {4'd0, v.expResult});
    check({tag, " err_count"}, {27'd0, err_count}, {27'd0, v.expErr});
    check({tag, " first_fail"}, {27'd0, first_fail}, {27'd0, v.expFirst});
    check({tag, " pass"}, {31'd0, pass}, {31'd0, v.expPass});
    tick();
    check({tag, " done@58"}, {31'd0, done}, 32'd0);
    check({tag, " gates hold"}, {27'd0, gate_type, gate_a, gate_b}, 32'h1B);
  endtask

  vec_t table_q[3];

  initial begin
    table_q[0] = '{mode: 0, expResult: 28'h96173E8, expErr: 5'd0,  expFirst: 5'h1F, expPass: 1'b1};
    table_q[1] = '{mode: 1, expResult: 28'h0000000, expErr: 5'd14, expFirst: 5'd3,  expPass: 1'b0};
    table_q[2] = '{mode: 2, expResult: 28'hFFFFFFF, expErr: 5'd14, expFirst: 5'd0,  expPass: 1'b0};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkReset("reset");

    for (int i = 0; i < 3; i++) begin
      mode = table_q[i].mode;
      runSweep($sformatf("vec%0d", i), table_q[i]);
    end

    // start re-pulsed at edge 20 must be ignored
    mode = 0;
    doneCount = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      start = (e == 20);
      tick();
      if (e == 57) check("restart done@57", {31'd0, done}, 32'd1);
    end
    start = 1'b0;
    check("restart result", {4'd0, result}, 32'h096173E8);
    check("restart err_count", {27'd0, err_count}, 32'd0);
    check("restart done pulses", doneCount, 32'd1);

    // reset at edge 25 of a correct sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 24; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("midrst");
    // reset wins over a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("rst+start busy", {31'd0, busy}, 32'd0);
    runSweep("postrst", table_q[0]);

    // start held high: second sweep accepted right after FINISH
    start = 1'b1;
    for (int e = 0; e <= 57; e++) tick();
    check("b2b done@57", {31'd0, done}, 32'd1);
    tick();
    start = 1'b0;
    check("b2b result cleared", {4'd0, result}, 32'd0);
    tick();
    check("b2b busy", {31'd0, busy}, 32'd1);
    for (int e = 2; e <= 57; e++) tick();
    check("b2b done2", {31'd0, done}, 32'd1);
    check("b2b result2", {4'd0, result}, 32'h096173E8);
    check("b2b pass2", {31'd0, pass}, 32'd1);
    tick();

    // SETTLE_CYCLES = 3: each vector held 4 cycles
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int e = 1; e <= 113; e++) begin
      tick();
      if (e == 1)   check("s3 busy@1", {31'd0, busy3}, 32'd1);
      if (e == 4)   check("s3 gate_b@4", {31'd0, gate_b3}, 32'd0);
      if (e == 5)   check("s3 gate_b@5", {31'd0, gate_b3}, 32'd1);
      if (e == 112) check("s3 done@112", {31'd0, done3}, 32'd0);
    end
    check("s3 done@113", {31'd0, done3}, 32'd1);
    check("s3 result", {4'd0, result3}, 32'h096173E8);
    check("s3 err_count", {27'd0, err_count3}, 32'd0);
    check("s3 first_fail", {27'd0, first_fail3}, 32'h1F);
    check("s3 pass", {31'd0, pass3}, 32'd1);
    tick();
    check("s3 done@114", {31'd0, done3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
